// File: rtl/cc_pkg.sv
// Shared condition-code types, one-hot constants and the bus classifier used by
// the LC-3 condition-code / branch-enable unit.
package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_NEG  = 3'b100;
  localparam cc_t CC_ZERO = 3'b010;
  localparam cc_t CC_POS  = 3'b001;

  // Widest bus the classifier handles; callers zero-extend into this.
  localparam int CC_MAX_W = 64;

  // Classify the low 'width' bits of value. A bit that is not a definite 0
  // (X or Z included) counts as non-zero, so the result is always one-hot.
  function automatic cc_t cc_classify(input logic [CC_MAX_W-1:0] value,
                                      input int width);
    logic sign;
    logic nonzero;
    cc_t  res;
    sign    = 1'b0;
    nonzero = 1'b0;
    for (int i = 0; i < CC_MAX_W; i++) begin
      if (i < width) begin
        if (value[i] !== 1'b0) nonzero = 1'b1;
        if (i == width - 1) sign = value[i];
      end
    end
    if (sign == 1'b1)   res = CC_NEG;
    else if (!nonzero)  res = CC_ZERO;
    else                res = CC_POS;
    return res;
  endfunction

endpackage

// File: rtl/cc_stack.sv
// DEPTH-entry LIFO of saved condition codes. Illegal requests (push when full,
// pop when empty, push and pop together) are dropped and flagged on err_o.
module cc_stack
  import cc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  cc_t                        data_i,
  output cc_t                        top_o,
  output logic                       pop_ok_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t           mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign pop_ok_o = pop_ok;
  // Only consumed when pop_ok is high, so the empty-case index is irrelevant.
  assign top_o    = mem_q[AW'(count_q - CW'(1))];

  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    err_o   = 1'b0;
    count_d = count_q;
    if (push_i && pop_i) begin
      err_o = 1'b1;
    end else if (push_i) begin
      if (full_o) begin
        err_o = 1'b1;
      end else begin
        push_ok = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop_i) begin
      if (empty_o) begin
        err_o = 1'b1;
      end else begin
        pop_ok  = 1'b1;
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry contents need no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[AW'(count_q)] <= data_i;
  end

endmodule

// File: rtl/cc_ben_unit.sv
// LC-3 condition-code unit: registered N/Z/P flags, branch enable and a saved-CC
// stack for interrupt entry / RTI. WIDTH must not exceed cc_pkg::CC_MAX_W.
module cc_ben_unit
  import cc_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter int         DEPTH    = 4,
  parameter logic [2:0] RESET_CC = 3'b000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           Bus,
  input  logic                       LD_CC,
  input  logic                       LD_BEN,
  input  logic [2:0]                 IR_nzp,
  input  logic                       CC_Push,
  input  logic                       CC_Pop,
  input  logic                       Err_Clr,
  output logic                       n,
  output logic                       z,
  output logic                       p,
  output logic                       BEN,
  output logic [$clog2(DEPTH+1)-1:0] Stack_Count,
  output logic                       Stack_Full,
  output logic                       Stack_Empty,
  output logic                       Stack_Err
);

  cc_t  cc_q, cc_d;
  cc_t  cls;
  cc_t  stk_top;
  logic stk_pop_ok;
  logic stk_err;
  logic ben_q, ben_d;
  logic err_q, err_d;

  // The stack always saves the registered flags, i.e. the pre-LD_CC value.
  cc_stack #(.DEPTH(DEPTH)) u_stack (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .push_i   (CC_Push),
    .pop_i    (CC_Pop),
    .data_i   (cc_q),
    .top_o    (stk_top),
    .pop_ok_o (stk_pop_ok),
    .count_o  (Stack_Count),
    .full_o   (Stack_Full),
    .empty_o  (Stack_Empty),
    .err_o    (stk_err)
  );

  always_comb begin
    cls   = cc_classify(CC_MAX_W'(Bus), WIDTH);
    cc_d  = cc_q;
    ben_d = ben_q;
    err_d = err_q;
    // A successful pop restores the saved flags and overrides LD_CC.
    if (stk_pop_ok)  cc_d = stk_top;
    else if (LD_CC)  cc_d = cls;
    if (LD_BEN) ben_d = |(IR_nzp & {cc_q.n, cc_q.z, cc_q.p});
    // A new error beats a same-cycle clear.
    if (stk_err)      err_d = 1'b1;
    else if (Err_Clr) err_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cc_q  <= cc_t'(RESET_CC);
      ben_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cc_q  <= cc_d;
      ben_q <= ben_d;
      err_q <= err_d;
    end
  end

  assign n         = cc_q.n;
  assign z         = cc_q.z;
  assign p         = cc_q.p;
  assign BEN       = ben_q;
  assign Stack_Err = err_q;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Bench for cc_ben_unit: directed walk through the main cases, then random
// traffic, checked against a queue-based reference model via a scoreboard.
module tb_cc_ben_unit;

  localparam int         WIDTH    = 16;
  localparam int         DEPTH    = 4;
  localparam logic [2:0] RESET_CC = 3'b000;
  localparam int         W        = 10;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Bus;
  logic        LD_CC, LD_BEN, CC_Push, CC_Pop, Err_Clr;
  logic [2:0]  IR_nzp;
  logic        n, z, p, BEN;
  logic [2:0]  Stack_Count;
  logic        Stack_Full, Stack_Empty, Stack_Err;

  always #5 Clk = ~Clk;

  cc_ben_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_CC(RESET_CC)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Bus         (Bus),
    .LD_CC       (LD_CC),
    .LD_BEN      (LD_BEN),
    .IR_nzp      (IR_nzp),
    .CC_Push     (CC_Push),
    .CC_Pop      (CC_Pop),
    .Err_Clr     (Err_Clr),
    .n           (n),
    .z           (z),
    .p           (p),
    .BEN         (BEN),
    .Stack_Count (Stack_Count),
    .Stack_Full  (Stack_Full),
    .Stack_Empty (Stack_Empty),
    .Stack_Err   (Stack_Err)
  );

  // ---------------- reference model ----------------
  logic [2:0] m_cc;
  logic       m_ben;
  logic       m_err;
  logic [2:0] m_stack[$];

  function automatic logic [2:0] ref_classify(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  // ---------------- driver ----------------
  task automatic drive(input string tag, input logic rst, input logic [15:0] bus,
                       input logic ldcc, input logic ldben, input logic [2:0] ir,
                       input logic push, input logic pop, input logic clr);
    logic [2:0] old_cc;
    logic [2:0] new_cc;
    logic       err_now;
    @(negedge Clk);
    Reset = rst; Bus = bus; LD_CC = ldcc; LD_BEN = ldben; IR_nzp = ir;
    CC_Push = push; CC_Pop = pop; Err_Clr = clr;
    if (rst) begin
      m_cc  = RESET_CC;
      m_ben = 1'b0;
      m_err = 1'b0;
      m_stack.delete();
    end else begin
      old_cc  = m_cc;
      err_now = 1'b0;
      new_cc  = ldcc ? ref_classify(bus) : old_cc;
      if (ldben) m_ben = |(ir & old_cc);
      if (push && pop) begin
        err_now = 1'b1;
      end else if (push) begin
        if (m_stack.size() == DEPTH) err_now = 1'b1;
        else m_stack.push_back(old_cc);
      end else if (pop) begin
        if (m_stack.size() == 0) err_now = 1'b1;
        else new_cc = m_stack.pop_back();
      end
      m_cc = new_cc;
      if (err_now)  m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    exp_q.push_back({m_cc, m_ben, 3'(m_stack.size()), m_stack.size() == DEPTH,
                     m_stack.size() == 0, m_err});
    tag_q.push_back(tag);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    string        t;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        got_v = {n, z, p, BEN, Stack_Count, Stack_Full, Stack_Empty, Stack_Err};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got nzp=%b ben=%b cnt=%0d full=%b empty=%b err=%b, expected nzp=%b ben=%b cnt=%0d full=%b empty=%b err=%b",
                   t, got_v[9:7], got_v[6], got_v[5:3], got_v[2], got_v[1], got_v[0],
                   exp_v[9:7], exp_v[6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; Bus = '0; LD_CC = 0; LD_BEN = 0; IR_nzp = '0;
    CC_Push = 0; CC_Pop = 0; Err_Clr = 0;

    drive("reset",      1, 16'h0000, 0, 0, 3'b000, 0, 0, 0);
    drive("ldcc_neg",   0, 16'h8000, 1, 0, 3'b000, 0, 0, 0);
    drive("ldcc_zero",  0, 16'h0000, 1, 0, 3'b000, 0, 0, 0);
    drive("ldcc_pos",   0, 16'h0001, 1, 0, 3'b000, 0, 0, 0);
    drive("set_zero",   0, 16'h0000, 1, 0, 3'b000, 0, 0, 0);
    drive("ben_z",      0, 16'h0000, 0, 1, 3'b010, 0, 0, 0);
    drive("ben_old_z",  0, 16'h0005, 1, 1, 3'b001, 0, 0, 0);

    drive("set_neg1",   0, 16'h8000, 1, 0, 3'b000, 0, 0, 0);
    drive("push1",      0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("set_zero2",  0, 16'h0000, 1, 0, 3'b000, 0, 0, 0);
    drive("push2",      0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("set_pos3",   0, 16'h0042, 1, 0, 3'b000, 0, 0, 0);
    drive("push3",      0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("set_neg4",   0, 16'hC000, 1, 0, 3'b000, 0, 0, 0);
    drive("push4_full", 0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("push_over",  0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("pop1",       0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    drive("pop2",       0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    drive("pop3",       0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    drive("pop4_empty", 0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
    drive("err_clr0",   0, 16'h0000, 0, 0, 3'b000, 0, 0, 1);
    drive("pop_empty",  0, 16'hFFFF, 1, 0, 3'b000, 0, 1, 0);
    drive("err_clr",    0, 16'h0000, 0, 0, 3'b000, 0, 0, 1);
    drive("set_pos",    0, 16'h0001, 1, 0, 3'b000, 0, 0, 0);
    drive("push_ldcc",  0, 16'h0000, 1, 0, 3'b000, 1, 0, 0);
    drive("pop_ldcc",   0, 16'h8000, 1, 0, 3'b000, 0, 1, 0);
    drive("push_a",     0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("push_b",     0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
    drive("push_pop",   0, 16'h0000, 0, 0, 3'b000, 1, 1, 0);
    drive("err_and_clr",0, 16'h0000, 0, 0, 3'b000, 1, 1, 1);
    drive("ben_load",   0, 16'h0000, 0, 1, 3'b111, 1, 0, 0);
    drive("reset_mid",  1, 16'h8000, 1, 1, 3'b111, 1, 0, 0);
    drive("after_rst",  0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] b;
      case ($urandom_range(0, 3))
        0:       b = 16'h0000;
        1:       b = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        default: b = 16'($urandom_range(0, 16'hFFFF));
      endcase
      drive("random",
            $urandom_range(0, 59) == 0,
            b,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
    end

    repeat (3) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
